reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 32-entry integer register file and stalls instruction issue on hazards.
- Sits between decode/issue and the register file.
- Counts outstanding writes per architectural register: incremented on issue, decremented on writeback.
- Raises a combinational stall when an issuing instruction reads or overwrites a register with a pending write.

Parameters:
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH entries tracked
- CNT_WIDTH, 2, per-register outstanding-write counter width; max outstanding = 2**CNT_WIDTH-1
- WAW_STALL, 1, 1 = stall issue when rd already has a pending write; 0 = allow WAW up to saturation
- STAT_WIDTH, 32, stall-cycle statistics counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs1  in  ADDRESS_WIDTH  source register 1
- issue_rs2  in  ADDRESS_WIDTH  source register 2
- issue_rd  in  ADDRESS_WIDTH  destination register
- issue_use_rs1  in  1  instruction reads rs1
- issue_use_rs2  in  1  instruction reads rs2
- issue_wr_rd  in  1  instruction writes rd
- wb_valid  in  1  writeback completes this cycle (same cycle as WE3 to the register file)
- wb_rd  in  ADDRESS_WIDTH  writeback destination
- stall  out  1  issue must hold; combinational from current state and inputs
- issue_fire  out  1  issue_valid && !stall
- busy_vec  out  2**ADDRESS_WIDTH  bit i = counter i nonzero
- err  out  1  sticky: writeback to a register with zero pending count
- stall_cycles  out  STAT_WIDTH  number of cycles with issue_valid && stall

Behaviour:
- Reset is synchronous and active-high (rst sampled on the rising edge of clk). It clears all counters, err and stall_cycles to 0, which makes busy_vec=0. stall and issue_fire are then 0 unless issue_valid is high.
- Register 0 is never tracked. Its counter is held at 0; issue and writeback to x0 are ignored; reads of x0 never stall.
- Let cnt[r] be the current counter value of register r.
- raw1 = issue_use_rs1 && rs1!=0 && cnt[rs1]!=0. raw2 is defined the same way for rs2.
- waw = WAW_STALL && issue_wr_rd && rd!=0 && cnt[rd]!=0.
- sat = issue_wr_rd && rd!=0 && cnt[rd]==2**CNT_WIDTH-1.
- stall = issue_valid && (raw1 || raw2 || waw || sat). stall is 0 when issue_valid=0.
- Counter update on each clock edge (non-reset), per register r≠0:
  - inc = issue_fire && issue_wr_rd && rd==r
  - dec = wb_valid && wb_rd==r
  - inc && !dec: cnt+1
  - dec && !inc: cnt-1, except when cnt==0: cnt stays 0 and err is set to 1
  - inc && dec: unchanged, even when cnt==0 (no error)
- Counters never wrap; the saturation stall guarantees this.
- stall_cycles increments by 1 on each edge where issue_valid && stall. It wraps modulo 2**STAT_WIDTH.
- err is cleared only by rst.
- Latency:
  - An accepted issue makes busy visible in the next cycle.
  - A writeback clears busy in the next cycle (unless the bypass feature is enabled).
- Reset asserted mid-operation discards all pending state. Writebacks arriving after reset for pre-reset issues are counted as errors (err=1).

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: the register file writes on the falling edge, so a same-cycle writeback is readable before the issue stage samples. A RAW/WAW term for register r is suppressed when wb_valid && wb_rd==r && cnt[r]==1.
- The saturation term is unaffected.
- Not defined: no suppression; stall follows the equations above exactly.

Test Plan:
- Reset, then issue rd=5 (issue_wr_rd=1); next cycle issue use_rs1=1 rs1=5 -> busy_vec[5]=1, stall=1, stall_cycles increments by 1 each held cycle; wb_rd=5 -> stall=0 in the following cycle.
- Issue writes to rd=0 and reads of rs1=0/rs2=0 repeatedly -> stall never asserted; busy_vec=0.
- WAW_STALL=0: three issues to rd=7 with no writeback -> cnt=3; a fourth issue to rd=7 -> stall=1 (sat); one wb_rd=7 -> fourth issue fires next cycle.
- Same cycle: issue_fire writing rd=9 plus wb_rd=9 while cnt[9]=1 -> cnt[9] stays 1, busy_vec[9]=1.
- wb_valid with wb_rd=12 while cnt[12]=0 -> err=1 next cycle and remains 1 until rst; cnt[12]=0.
- SB_WB_BYPASS_EN defined, cnt[3]=1, issue rs2=3 with wb_rd=3 in the same cycle -> stall=0 and issue_fire=1. Without the macro -> stall=1 for that cycle.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Purpose : per-register outstanding-write counters for the integer register file; stalls issue on RAW/WAW/saturation hazards.
// Latency : stall/issue_fire are combinational; counter, busy_vec, err and stall_cycles update on the next rising edge.
// Backpres: stall holds decode; writeback is never backpressured. Optional macro SB_WB_BYPASS_EN lets a same-cycle writeback clear a RAW/WAW hazard.
module reg_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 2,
  parameter bit WAW_STALL     = 1'b1,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs1,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs2,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rd,
  input  logic                        issue_use_rs1,
  input  logic                        issue_use_rs2,
  input  logic                        issue_wr_rd,
  input  logic                        wb_valid,
  input  logic [ADDRESS_WIDTH-1:0]    wb_rd,
  output logic                        stall,
  output logic                        issue_fire,
  output logic [2**ADDRESS_WIDTH-1:0] busy_vec,
  output logic                        err,
  output logic [STAT_WIDTH-1:0]       stall_cycles
);

  localparam int NUM_REGS = 2**ADDRESS_WIDTH;
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]     CNT_ZERO = '0;
  localparam logic [ADDRESS_WIDTH-1:0] X0       = '0;

  // Individual hazard terms kept together so the stall reduction stays readable.
  typedef struct packed {
    logic raw1;
    logic raw2;
    logic waw;
    logic sat;
  } hazard_t;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];

  logic [CNT_WIDTH-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic                 byp_rs1, byp_rs2, byp_rd;
  hazard_t              haz;
  logic                 inc_en, dec_en, same_reg, err_set;

  // Look up the counters addressed by the current issue and writeback.
  always_comb begin
    cnt_rs1 = cnt_q[issue_rs1];
    cnt_rs2 = cnt_q[issue_rs2];
    cnt_rd  = cnt_q[issue_rd];
    cnt_wb  = cnt_q[wb_rd];
  end

  // A writeback retiring the last pending write makes the value readable this cycle
  // only when the register file writes on the falling edge.
  always_comb begin
`ifdef SB_WB_BYPASS_EN
    byp_rs1 = wb_valid && (wb_rd == issue_rs1) && (cnt_rs1 == CNT_ONE);
    byp_rs2 = wb_valid && (wb_rd == issue_rs2) && (cnt_rs2 == CNT_ONE);
    byp_rd  = wb_valid && (wb_rd == issue_rd)  && (cnt_rd  == CNT_ONE);
`else
    byp_rs1 = 1'b0;
    byp_rs2 = 1'b0;
    byp_rd  = 1'b0;
`endif
  end

  // Hazard detection; x0 never creates a hazard and saturation ignores the bypass.
  always_comb begin
    haz      = '0;
    haz.raw1 = issue_use_rs1 && (issue_rs1 != X0) && (cnt_rs1 != CNT_ZERO) && !byp_rs1;
    haz.raw2 = issue_use_rs2 && (issue_rs2 != X0) && (cnt_rs2 != CNT_ZERO) && !byp_rs2;
    haz.waw  = WAW_STALL && issue_wr_rd && (issue_rd != X0) && (cnt_rd != CNT_ZERO) && !byp_rd;
    haz.sat  = issue_wr_rd && (issue_rd != X0) && (cnt_rd == CNT_MAX);
    stall      = issue_valid && (|haz);
    issue_fire = issue_valid && !stall;
  end

  // Counter update controls; an issue and writeback to the same register cancel out.
  always_comb begin
    inc_en   = issue_fire && issue_wr_rd && (issue_rd != X0);
    dec_en   = wb_valid && (wb_rd != X0);
    same_reg = inc_en && dec_en && (issue_rd == wb_rd);
    err_set  = dec_en && !same_reg && (cnt_wb == CNT_ZERO);
  end

  // Per-register counters, sticky error flag and stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      err          <= 1'b0;
      stall_cycles <= '0;
    end else begin
      cnt_q[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (!same_reg) begin
          if (inc_en && (issue_rd == ADDRESS_WIDTH'(r))) begin
            cnt_q[r] <= cnt_q[r] + CNT_ONE;
          end else if (dec_en && (wb_rd == ADDRESS_WIDTH'(r)) && (cnt_q[r] != CNT_ZERO)) begin
            cnt_q[r] <= cnt_q[r] - CNT_ONE;
          end
        end
      end
      err <= err | err_set;
      if (stall) begin
        stall_cycles <= stall_cycles + STAT_WIDTH'(1);
      end
    end
  end

  // Busy view of the counters for downstream status.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt_q[r] != CNT_ZERO);
    end
  end

endmodule
